// File: rtl/clock_gate_ctrl.sv
// Per-channel idle-driven clock gating with hysteresis, staged wake-up and
// an all-channels-gated cycle counter.
module clock_gate_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  chan_busy,
  input  logic [N_CH-1:0]  chan_req,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic [N_CH-1:0]  chan_en,
  output logic [N_CH-1:0]  chan_ready,
  output logic [N_CH-1:0]  gated_clk,
  output logic [CNT_W-1:0] all_off_cnt
);

  localparam int unsigned MaxCycles = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_CYCLES - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WAKE_CYCLES - 1);

  localparam logic [1:0] StOn       = 2'd0;
  localparam logic [1:0] StIdleWait = 2'd1;
  localparam logic [1:0] StOff      = 2'd2;
  localparam logic [1:0] StWake     = 2'd3;

  logic [1:0]      state_q [N_CH];
  logic [1:0]      state_d [N_CH];
  logic [CntW-1:0] cnt_q   [N_CH];
  logic [CntW-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0] act;
  logic [N_CH-1:0] en_lat;
  logic [CNT_W-1:0] all_off_cnt_q;
  logic            all_off;

  assign act = chan_busy | chan_req | {N_CH{force_on}};

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StOn: begin
          cnt_d[i] = '0;
          if (!act[i]) begin
            if (IDLE_CYCLES == 1) begin
              state_d[i] = StOff;
            end else begin
              state_d[i] = StIdleWait;
              cnt_d[i]   = CntW'(1);
            end
          end
        end
        StIdleWait: begin
          if (act[i]) begin
            state_d[i] = StOn;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == IdleLast) begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StOff: begin
          cnt_d[i] = '0;
          if (act[i]) state_d[i] = StWake;
        end
        StWake: begin
          // Wake always runs to completion; ON re-evaluates activity afterwards.
          if (cnt_q[i] == WakeLast) begin
            state_d[i] = StOn;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        default: begin
          state_d[i] = StOn;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_CH); i++) begin
      if (rst) begin
        state_q[i] <= StOn;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      chan_en[i]    = (state_q[i] != StOff);
      chan_ready[i] = (state_q[i] == StOn) || (state_q[i] == StIdleWait);
    end
  end

  assign all_off = ~|chan_en;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      all_off_cnt_q <= '0;
    end else if (all_off && (all_off_cnt_q != {CNT_W{1'b1}})) begin
      all_off_cnt_q <= all_off_cnt_q + CNT_W'(1);
    end
  end

  assign all_off_cnt = all_off_cnt_q;

  // Enable is captured while clk is low so a high phase is either whole or absent.
  always_latch begin
    if (!clk) en_lat = chan_en;
  end

  assign gated_clk = {N_CH{clk}} & en_lat;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: cycle scoreboard against a behavioural
// model, directed scenario checks and gated-clock pulse-width monitoring.
`timescale 1ns/10ps
module tb_clock_gate_ctrl;

  localparam int NCh  = 4;
  localparam int Idle = 4;
  localparam int Wake = 2;
  localparam int CntW = 4;

  logic            clk;
  logic            rst;
  logic [NCh-1:0]  chan_busy;
  logic [NCh-1:0]  chan_req;
  logic            force_on;
  logic            cnt_clr;
  logic [NCh-1:0]  chan_en;
  logic [NCh-1:0]  chan_ready;
  logic [NCh-1:0]  gated_clk;
  logic [CntW-1:0] all_off_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;

  clock_gate_ctrl #(
    .N_CH       (NCh),
    .IDLE_CYCLES(Idle),
    .WAKE_CYCLES(Wake),
    .CNT_W      (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .chan_busy  (chan_busy),
    .chan_req   (chan_req),
    .force_on   (force_on),
    .cnt_clr    (cnt_clr),
    .chan_en    (chan_en),
    .chan_ready (chan_ready),
    .gated_clk  (gated_clk),
    .all_off_cnt(all_off_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: idle run length and wake countdown per channel.
  typedef struct packed {
    logic [NCh-1:0]  en;
    logic [NCh-1:0]  rdy;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [NCh-1:0] m_en;
  logic [NCh-1:0] m_rdy;
  int             m_run  [NCh];
  int             m_wake [NCh];
  int             m_cnt;

  always @(posedge clk) begin
    exp_t e;
    bit   was_all_off;
    if (rst) begin
      armed = 1;
      m_en  = '1;
      m_rdy = '1;
      m_cnt = 0;
      for (int i = 0; i < NCh; i++) begin
        m_run[i]  = 0;
        m_wake[i] = 0;
      end
    end else if (armed) begin
      was_all_off = (m_en == '0);
      for (int i = 0; i < NCh; i++) begin
        bit a;
        a = chan_busy[i] | chan_req[i] | force_on;
        if (m_wake[i] > 0) begin
          m_wake[i]--;
          if (m_wake[i] == 0) m_rdy[i] = 1'b1;
        end else if (!m_en[i]) begin
          if (a) begin
            m_en[i]   = 1'b1;
            m_wake[i] = Wake;
          end
        end else begin
          m_run[i] = a ? 0 : m_run[i] + 1;
          if (m_run[i] == Idle) begin
            m_en[i]  = 1'b0;
            m_rdy[i] = 1'b0;
            m_run[i] = 0;
          end
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (was_all_off && m_cnt < 15) m_cnt++;
    end
    if (armed) begin
      e.en  = m_en;
      e.rdy = m_rdy;
      e.cnt = CntW'(m_cnt);
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      check("sb_en", 32'(chan_en), 32'(e.en));
      check("sb_rdy", 32'(chan_ready), 32'(e.rdy));
      check("sb_cnt", 32'(all_off_cnt), 32'(e.cnt));
    end
  end

  // Every gated high phase must span the whole clk high phase (500 x 10ps).
  for (genvar g = 0; g < NCh; g++) begin : g_mon
    realtime t_rise;
    int      n = 0;
    always @(posedge gated_clk[g]) begin
      t_rise = $realtime;
      n++;
    end
    always @(negedge gated_clk[g]) begin
      if (armed) check($sformatf("pulse_w%0d", g), 32'(int'(($realtime - t_rise) * 100.0)), 32'd500);
    end
  end

  function automatic int pulse_sum();
    return g_mon[0].n + g_mon[1].n + g_mon[2].n + g_mon[3].n;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int c;
    rst       = 1'b1;
    chan_busy = '0;
    chan_req  = '0;
    force_on  = 1'b0;
    cnt_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(chan_en), 32'hf);
    check("rst_rdy", 32'(chan_ready), 32'hf);
    check("rst_cnt", 32'(all_off_cnt), 32'h0);

    // Idle gating after reset release
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_en_3", 32'(chan_en), 32'hf);
    @(negedge clk);
    check("idle_en_4", 32'(chan_en), 32'h0);
    p = pulse_sum();
    repeat (5) @(negedge clk);
    check("no_pulses", 32'(pulse_sum()), 32'(p));
    check("cnt_run", 32'(all_off_cnt), 32'd5);

    // Counter clear, clear-vs-increment, saturation
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr", 32'(all_off_cnt), 32'd0);
    repeat (9) @(negedge clk);
    check("cnt_9", 32'(all_off_cnt), 32'd9);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr_wins", 32'(all_off_cnt), 32'd0);
    repeat (20) @(negedge clk);
    check("cnt_sat", 32'(all_off_cnt), 32'd15);

    // Wake latency on channel 2
    c = g_mon[2].n;
    chan_req[2] = 1'b1;
    @(negedge clk);
    chan_req[2] = 1'b0;
    check("wake_en", 32'(chan_en), 32'b0100);
    check("wake_rdy1", 32'(chan_ready[2]), 32'd0);
    check("wake_nopulse", 32'(g_mon[2].n), 32'(c));
    @(negedge clk);
    check("wake_pulse", 32'(g_mon[2].n), 32'(c + 1));
    check("wake_rdy2", 32'(chan_ready[2]), 32'd0);
    @(negedge clk);
    check("wake_rdy3", 32'(chan_ready), 32'b0100);
    repeat (6) @(negedge clk);
    check("wake_regate", 32'(chan_en), 32'h0);

    // Global override
    force_on = 1'b1;
    repeat (2) @(negedge clk);
    check("force_rdy2", 32'(chan_ready), 32'h0);
    @(negedge clk);
    check("force_rdy3", 32'(chan_ready), 32'hf);
    repeat (8) @(negedge clk);
    check("force_hold", 32'(chan_en), 32'hf);

    // Hysteresis restart on channel 1
    force_on = 1'b0;
    repeat (3) @(negedge clk);
    check("hyst_idle3", 32'(chan_en), 32'hf);
    chan_busy[1] = 1'b1;
    @(negedge clk);
    chan_busy[1] = 1'b0;
    check("hyst_others", 32'(chan_en), 32'b0010);
    repeat (3) @(negedge clk);
    check("hyst_hold", 32'(chan_en[1]), 32'd1);
    @(negedge clk);
    check("hyst_off", 32'(chan_en[1]), 32'd0);

    // Activity changes at arbitrary points in the clock phase
    repeat (60) begin
      #($urandom_range(3, 17) * 0.5 + 0.25);
      chan_busy = NCh'($urandom);
    end
    @(negedge clk);
    chan_busy = '0;
    repeat (8) @(negedge clk);
    check("async_settle", 32'(chan_en), 32'h0);

    // Reset during wake
    chan_req[0] = 1'b1;
    @(negedge clk);
    chan_req[0] = 1'b0;
    check("rstw_wake", 32'(chan_ready[0]), 32'd0);
    c = g_mon[1].n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_rdy", 32'(chan_ready), 32'hf);
    check("rstw_nopulse", 32'(g_mon[1].n), 32'(c));
    @(negedge clk);
    check("rstw_resume", 32'(g_mon[1].n), 32'(c + 1));
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independently gated clock channels (1..32).
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 16, giving the consecutive idle samples required before a channel is gated (>=1).
REQ-003 The block SHALL have parameter WAKE_CYCLES, default 2, giving the cycles a channel clock runs before ready is asserted (>=1).
REQ-004 The block SHALL have parameter CNT_W, default 32, giving the width of the all-gated cycle counter.
REQ-005 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-006 Port clk SHALL be an input, 1 bit wide: the free-running main clock.
REQ-007 Port rst SHALL be an input, 1 bit wide: the synchronous, active-high reset.
REQ-008 Port chan_busy SHALL be an input, N_CH bits wide: per-channel activity flag (for example, SHA FSM not IDLE).
REQ-009 Port chan_req SHALL be an input, N_CH bits wide: per-channel wake or keep-alive request (for example, start_sha).
REQ-010 Port force_on SHALL be an input, 1 bit wide: global override that keeps or brings every channel on (test/debug).
REQ-011 Port cnt_clr SHALL be an input, 1 bit wide: synchronous clear of all_off_cnt.
REQ-012 Port chan_en SHALL be an output, N_CH bits wide: registered per-channel clock enable.
REQ-013 Port chan_ready SHALL be an output, N_CH bits wide: the channel clock is stable and the client may start work.
REQ-014 Port gated_clk SHALL be an output, N_CH bits wide: the per-channel gated clock.
REQ-015 Port all_off_cnt SHALL be an output, CNT_W bits wide: count of cycles in which every channel was gated.

Function
REQ-016 Each channel SHALL run an independent FSM with states ON, IDLE_WAIT, OFF and WAKE, plus a counter wide enough for max(IDLE_CYCLES, WAKE_CYCLES).
REQ-017 A channel's activity SHALL be defined as act[i] = chan_busy[i] | chan_req[i] | force_on.
REQ-018 In ON with act, the channel SHALL stay in ON; without act it SHALL go to OFF if IDLE_CYCLES==1, else to IDLE_WAIT with cnt=1.
REQ-019 In IDLE_WAIT with act, the channel SHALL return to ON (cnt cleared); without act it SHALL go to OFF if cnt==IDLE_CYCLES-1, else increment cnt.
REQ-020 Consequently, chan_en[i] SHALL fall exactly IDLE_CYCLES cycles after the first of IDLE_CYCLES consecutive idle samples, and any active sample SHALL restart the count.
REQ-021 In OFF with act, the channel SHALL go to WAKE with cnt=0; otherwise it SHALL stay in OFF.
REQ-022 In WAKE, cnt SHALL increment each cycle, and the channel SHALL go to ON when cnt==WAKE_CYCLES-1; the wake sequence SHALL NOT be aborted by act deasserting, and ON then re-evaluates per REQ-018.
REQ-023 chan_en[i] SHALL be 1 in ON, IDLE_WAIT and WAKE, and 0 in OFF; chan_ready[i] SHALL be 1 in ON and IDLE_WAIT, and 0 in OFF and WAKE.
REQ-024 Latency from act rising in OFF SHALL be: chan_en high one cycle later, chan_ready high WAKE_CYCLES+1 cycles later.
REQ-025 gated_clk[i] SHALL be clk AND en_lat[i], where en_lat[i] is a latch that is transparent while clk is low and loaded from chan_en[i]; the output SHALL be glitch-free, with no partial high pulses.
REQ-026 Gating SHALL NOT be implemented as a bare AND of clk with a registered enable.
REQ-027 Simultaneous act on several channels SHALL wake all of them in parallel, with no arbitration or staggering.
REQ-028 all_off_cnt SHALL increment by 1 on each cycle in which chan_en == 0 for every channel, and SHALL saturate at all-ones without wrapping.
REQ-029 When cnt_clr coincides with an increment, clear SHALL win and all_off_cnt SHALL be 0 on the next cycle.
REQ-030 Asserting force_on while a channel is in WAKE SHALL have no extra effect, because the wake sequence completes regardless (REQ-022).

Reset
REQ-031 While rst=1 at a rising edge, every channel SHALL enter ON with cnt=0, and all_off_cnt SHALL become 0.
REQ-032 After reset, chan_en SHALL be all-ones and chan_ready SHALL be all-ones, so that downstream registers receive clocks to reset.
REQ-033 Reset asserted mid-IDLE_WAIT, mid-WAKE or in OFF SHALL return the channel to ON on the next edge, with gated_clk resuming at the following clk high phase.
REQ-034 The en_lat latches SHALL follow chan_en, so no latch-specific reset is required.

Verification
REQ-035 Idle gating (N_CH=4, IDLE_CYCLES=4, WAKE_CYCLES=2): release reset with all inputs at 0 -> chan_en=4'b0000 from the 4th cycle after reset release, and gated_clk shows no pulses afterwards.
REQ-036 Hysteresis restart: hold channel 1 idle for 3 cycles, pulse chan_busy[1] for 1 cycle, then go idle -> chan_en[1] stays 1 until 4 further idle cycles have elapsed.
REQ-037 Wake latency: pulse chan_req[2] for 1 cycle while channel 2 is in OFF -> chan_en[2]=1 at +1 cycle, chan_ready[2]=1 at +3 cycles, and the first full gated_clk[2] pulse appears in the cycle after chan_en rises.
REQ-038 Override: raise force_on while all channels are in OFF -> all four chan_ready=1 after 3 cycles, and no channel gates while force_on stays 1.
REQ-039 Counter: with all channels off for 10 cycles, then cnt_clr asserted on the 10th cycle -> all_off_cnt reads 9 before the clear and 0 after it; with CNT_W=4 and all channels off for 20 cycles -> all_off_cnt holds at 15.
REQ-040 Glitch check: toggle chan_busy asynchronously to the clk phase -> every gated_clk high pulse has the full clk high width (checked by an assertion), and asserting rst mid-WAKE returns chan_ready=1 on the next cycle.
